attack_ctrl: RTL and testbench
==============================

// Module: attack_ctrl
// PURPOSE
//  Player-side attack initiator. Each accepted fire press produces one timed hit strobe
//  on one of three enemy lanes, together with a latched 5-bit hit position.
//  Enemy blocks return a registered per-lane damage flag, which this block turns into
//  a score. It also tracks ammo and reload, and it keeps a live aim cursor for drawing.
// PARAMETERS
//  WINDUP_CYC    2         cycles from accepted fire to hit assertion (>=1)
//  STRIKE_CYC    4         cycles the hit strobe is held high (>=2)
//  COOLDOWN_CYC  12500000  dead cycles after a strike, before the next fire is accepted (>=1)
//  RELOAD_CYC    50000000  cycles to refill ammo (>=1)
//  AMMO_MAX      8         ammo capacity (1..15)
//  POS_MAX       24        highest aim/hit position
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  fire       in   1   fire button level (pre-debounced); acts on the rising edge
//  reload     in   1   reload button level; acts on the rising edge
//  aim_left   in   1   rising edge: aim_pos - 1
//  aim_right  in   1   rising edge: aim_pos + 1
//  lane_sel   in   2   target lane 0..2; value 3 = no lane
//  damage     in   3   per-lane damage flag from the enemies; lags hit by 1 cycle
//  hit        out  3   one-hot strike strobe; hit[i] drives the lane-i enemy
//  hit_pos    out  5   position latched at fire; valid whenever hit != 0
//  aim_pos    out  5   live cursor position
//  ammo       out  4   rounds remaining
//  score      out  8   confirmed hits, saturating at 255
//  busy       out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, hit=0, hit_pos=0, aim_pos=POS_MAX/2 (12), ammo=AMMO_MAX,
//    score=0, busy=0. All edge-detect history registers clear to 0.
//  Reset is asynchronous at any point. A strike in progress is dropped immediately:
//    hit goes to 0 with no glitch and no score is counted.
//  Edge detect: each button is registered once. An edge means the current sample is 1
//    and the previous sample was 0. Holding a button never repeats its action.
//  Aim: aim_pos updates in every state.
//    - Saturates at 0 and at POS_MAX; it never wraps.
//    - A left edge and a right edge in the same cycle leave aim_pos unchanged.
//  FSM states: IDLE, WINDUP, STRIKE, COOLDOWN, RELOAD.
//  IDLE, fire edge, with ammo>0 and lane_sel!=3:
//    - go to WINDUP and latch lane=lane_sel and hit_pos=aim_pos;
//    - decrement ammo on the same edge.
//  IDLE, fire edge otherwise (ammo=0 or lane_sel=3): ignored, ammo unchanged.
//  IDLE, reload edge with ammo<AMMO_MAX: go to RELOAD.
//    If fire is accepted in the same cycle, fire wins and the reload edge is dropped.
//  WINDUP: lasts WINDUP_CYC cycles, then STRIKE.
//  STRIKE: hit[lane]=1 for exactly STRIKE_CYC cycles, then COOLDOWN. All other hit bits stay 0.
//  COOLDOWN: lasts COOLDOWN_CYC cycles, then IDLE.
//  RELOAD: lasts RELOAD_CYC cycles. On the final cycle ammo=AMMO_MAX, then IDLE.
//  Timing: take the cycle in which the fire edge is sampled as cycle 0.
//    Then busy=1 from cycle 1, and hit is high in cycles WINDUP_CYC+1 .. WINDUP_CYC+STRIKE_CYC.
//  Fire and reload edges in any state other than IDLE are discarded, not queued.
//  Scoring: damage[lane] is accepted from the 2nd STRIKE cycle through the 1st COOLDOWN cycle.
//    - The first accepted 1 increments score, once per strike.
//    - Bits of damage outside the latched lane are ignored.
//    - damage outside this window is ignored.
//  Width: the ammo and score counters never under- or overflow.
//    Ammo decrements only when ammo>0; score holds at 255.
// TESTING (WINDUP=2 STRIKE=4 COOLDOWN=8 RELOAD=10 AMMO_MAX=3 POS_MAX=24)
//  1. Fire edge at cycle 0, lane 2, aim 12, damage[2] looped as hit[2] delayed 1 cycle
//     -> hit=3'b100 in cycles 3-6, hit_pos=12, ammo 3->2, score=1, IDLE at cycle 15.
//  2. Hold fire high for 40 cycles
//     -> exactly one strike; a second fire edge arriving during COOLDOWN produces no strike.
//  3. Fire 3 times (ammo 0), then fire again -> no strike. Reload edge -> busy for 10 cycles,
//     then ammo=3. Fire and reload together at ammo=2 -> strike, ammo=1.
//  4. 30 right edges from aim 12 -> aim_pos=24. Left and right edges in the same cycle
//     -> no change. 30 left edges -> aim_pos=0.
//  5. lane_sel=3 + fire -> ignored. lane 1 strike with damage[0]=1 only -> score unchanged.
//     Moving aim during STRIKE -> hit_pos holds its latched value.
//  6. Assert rst during cycle 4 of a strike -> hit=0 immediately, ammo=3, score=0, IDLE.

Source files
------------

// File: rtl/attack_ctrl.sv
// Player attack initiator: fire -> windup -> timed lane strike -> cooldown,
// plus ammo/reload tracking, damage-confirmed scoring and a live aim cursor.
module attack_ctrl #(
  parameter int unsigned WINDUP_CYC   = 2,
  parameter int unsigned STRIKE_CYC   = 4,
  parameter int unsigned COOLDOWN_CYC = 12500000,
  parameter int unsigned RELOAD_CYC   = 50000000,
  parameter int unsigned AMMO_MAX     = 8,
  parameter int unsigned POS_MAX      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic       reload,
  input  logic       aim_left,
  input  logic       aim_right,
  input  logic [1:0] lane_sel,
  input  logic [2:0] damage,
  output logic [2:0] hit,
  output logic [4:0] hit_pos,
  output logic [4:0] aim_pos,
  output logic [3:0] ammo,
  output logic [7:0] score,
  output logic       busy
);

  localparam int unsigned MAX_AB  = (WINDUP_CYC > STRIKE_CYC) ? WINDUP_CYC : STRIKE_CYC;
  localparam int unsigned MAX_CD  = (COOLDOWN_CYC > RELOAD_CYC) ? COOLDOWN_CYC : RELOAD_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [4:0] POS_TOP  = 5'(POS_MAX);
  localparam logic [4:0] POS_MID  = 5'(POS_MAX / 2);
  localparam logic [3:0] AMMO_TOP = 4'(AMMO_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WINDUP,
    S_STRIKE,
    S_COOLDOWN,
    S_RELOAD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lane_q, lane_d;
  logic [2:0]         hit_q, hit_d;
  logic [4:0]         hit_pos_q, hit_pos_d;
  logic [4:0]         aim_q, aim_d;
  logic [3:0]         ammo_q, ammo_d;
  logic [7:0]         score_q, score_d;
  logic               scored_q, scored_d;
  logic               busy_q, busy_d;
  logic               fire_q, reload_q, left_q, right_q;

  logic               fire_edge_c, reload_edge_c, left_edge_c, right_edge_c;
  logic               fire_ok_c, score_win_c;
  logic [2:0]         lane_mask_c;

  // Button history: one register per button, edge = now 1, before 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_q   <= 1'b0;
      reload_q <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      fire_q   <= fire;
      reload_q <= reload;
      left_q   <= aim_left;
      right_q  <= aim_right;
    end
  end

  // Edge detects, fire acceptance and the scoring window
  always_comb begin
    fire_edge_c   = fire & ~fire_q;
    reload_edge_c = reload & ~reload_q;
    left_edge_c   = aim_left & ~left_q;
    right_edge_c  = aim_right & ~right_q;
    fire_ok_c     = (state_q == S_IDLE) && fire_edge_c && (ammo_q != 4'd0) && (lane_sel != 2'd3);
    score_win_c   = ((state_q == S_STRIKE) && (cnt_q != '0)) ||
                    ((state_q == S_COOLDOWN) && (cnt_q == '0));
    case (lane_q)
      2'd0:    lane_mask_c = 3'b001;
      2'd1:    lane_mask_c = 3'b010;
      2'd2:    lane_mask_c = 3'b100;
      default: lane_mask_c = 3'b000;
    endcase
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    hit_pos_d = hit_pos_q;
    aim_d     = aim_q;
    ammo_d    = ammo_q;
    score_d   = score_q;
    scored_d  = scored_q;
    hit_d     = 3'b000;
    busy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fire_ok_c) begin
          state_d   = S_WINDUP;
          cnt_d     = '0;
          lane_d    = lane_sel;
          hit_pos_d = aim_q;
          ammo_d    = ammo_q - 4'd1;
          scored_d  = 1'b0;
        end else if (reload_edge_c && (ammo_q < AMMO_TOP)) begin
          state_d = S_RELOAD;
          cnt_d   = '0;
        end
      end
      S_WINDUP: begin
        if (cnt_q == CNT_W'(WINDUP_CYC - 1)) begin
          state_d = S_STRIKE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STRIKE: begin
        if (cnt_q == CNT_W'(STRIKE_CYC - 1)) begin
          state_d = S_COOLDOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (cnt_q == CNT_W'(COOLDOWN_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELOAD: begin
        if (cnt_q == CNT_W'(RELOAD_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Ammo shows full during the last reload cycle
    if ((state_d == S_RELOAD) && (cnt_d == CNT_W'(RELOAD_CYC - 1))) begin
      ammo_d = AMMO_TOP;
    end

    // First damage on the latched lane inside the window scores once
    if (score_win_c && !scored_q && ((damage & lane_mask_c) != 3'b000)) begin
      scored_d = 1'b1;
      if (score_q != 8'hFF) begin
        score_d = score_q + 8'd1;
      end
    end

    // Strobe decoded from the next state so it lines up with the state register
    if (state_d == S_STRIKE) begin
      case (lane_d)
        2'd0:    hit_d = 3'b001;
        2'd1:    hit_d = 3'b010;
        2'd2:    hit_d = 3'b100;
        default: hit_d = 3'b000;
      endcase
    end
    busy_d = (state_d != S_IDLE);

    // Saturating cursor; simultaneous left/right cancel
    if (left_edge_c && !right_edge_c && (aim_q != 5'd0)) begin
      aim_d = aim_q - 5'd1;
    end else if (right_edge_c && !left_edge_c && (aim_q < POS_TOP)) begin
      aim_d = aim_q + 5'd1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lane_q    <= 2'd0;
      hit_q     <= 3'b000;
      hit_pos_q <= 5'd0;
      aim_q     <= POS_MID;
      ammo_q    <= AMMO_TOP;
      score_q   <= 8'd0;
      scored_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      hit_q     <= hit_d;
      hit_pos_q <= hit_pos_d;
      aim_q     <= aim_d;
      ammo_q    <= ammo_d;
      score_q   <= score_d;
      scored_q  <= scored_d;
      busy_q    <= busy_d;
    end
  end

  assign hit     = hit_q;
  assign hit_pos = hit_pos_q;
  assign aim_pos = aim_q;
  assign ammo    = ammo_q;
  assign score   = score_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_attack_ctrl.sv
// Directed bench for attack_ctrl with short timing parameters.
module tb_attack_ctrl;

  logic       clk;
  logic       rst;
  logic       fire;
  logic       reload;
  logic       aim_left;
  logic       aim_right;
  logic [1:0] lane_sel;
  logic [2:0] damage;
  logic [2:0] hit;
  logic [4:0] hit_pos;
  logic [4:0] aim_pos;
  logic [3:0] ammo;
  logic [7:0] score;
  logic       busy;

  logic       loop_en;
  logic [2:0] dmg_manual;
  logic [2:0] hit_dly;

  int checks;
  int passes;

  attack_ctrl #(
    .WINDUP_CYC  (2),
    .STRIKE_CYC  (4),
    .COOLDOWN_CYC(8),
    .RELOAD_CYC  (10),
    .AMMO_MAX    (3),
    .POS_MAX     (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fire     (fire),
    .reload   (reload),
    .aim_left (aim_left),
    .aim_right(aim_right),
    .lane_sel (lane_sel),
    .damage   (damage),
    .hit      (hit),
    .hit_pos  (hit_pos),
    .aim_pos  (aim_pos),
    .ammo     (ammo),
    .score    (score),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enemy model: damage flag mirrors hit one cycle later
  always @(posedge clk) hit_dly <= hit;
  assign damage = loop_en ? hit_dly : dmg_manual;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    fire = 0; reload = 0; aim_left = 0; aim_right = 0;
    lane_sel = 2'd0; dmg_manual = 3'b000; loop_en = 0;
    rst = 0;
    tick();
    tick();
    rst = 1;
    tick();
  endtask

  // Presses fire at cycle 0 and records the strike profile until idle
  task automatic run_strike(input logic [1:0] lane, input int dmg_lo, input int dmg_hi,
                            input logic [2:0] dmg_bits, input int aim_cyc,
                            output int first_hit, output int last_hit,
                            output logic [2:0] hit_or, output logic [4:0] pos_seen,
                            output int idle_cyc, output logic busy1);
    first_hit = -1; last_hit = -1; hit_or = 3'b000; pos_seen = 5'd0;
    idle_cyc = -1; busy1 = 1'b0;
    lane_sel = lane;
    fire = 1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) begin
        fire = 0;
        busy1 = busy;
      end
      aim_right  = (c == aim_cyc);
      dmg_manual = (c >= dmg_lo && c <= dmg_hi) ? dmg_bits : 3'b000;
      if (hit != 3'b000) begin
        if (first_hit < 0) first_hit = c;
        last_hit = c;
        hit_or   = hit_or | hit;
        pos_seen = hit_pos;
      end
      if (!busy) begin
        idle_cyc = c;
        break;
      end
    end
    dmg_manual = 3'b000;
    aim_right  = 0;
    tick();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (hit !== 3'b000) $display("FAIL reset_hit: got %b expected 000", hit); else passes++;
    checks++; if (hit_pos !== 5'd0) $display("FAIL reset_hit_pos: got %0d expected 0", hit_pos); else passes++;
    checks++; if (aim_pos !== 5'd12) $display("FAIL reset_aim: got %0d expected 12", aim_pos); else passes++;
    checks++; if (ammo !== 4'd3) $display("FAIL reset_ammo: got %0d expected 3", ammo); else passes++;
    checks++; if (score !== 8'd0) $display("FAIL reset_score: got %0d expected 0", score); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_single_strike();
    int fh, lh, ic;
    logic [2:0] ho;
    logic [4:0] ps;
    logic b1;
    reset_dut();
    loop_en = 1;
    run_strike(2'd2, 0, -1, 3'b000, 0, fh, lh, ho, ps, ic, b1);
    loop_en = 0;
    checks++; if (b1 !== 1'b1) $display("FAIL s1_busy_c1: got %b expected 1", b1); else passes++;
    checks++; if (fh != 3) $display("FAIL s1_first_hit: got %0d expected 3", fh); else passes++;
    checks++; if (lh != 6) $display("FAIL s1_last_hit: got %0d expected 6", lh); else passes++;
    checks++; if (ho !== 3'b100) $display("FAIL s1_hit_val: got %b expected 100", ho); else passes++;
    checks++; if (ps !== 5'd12) $display("FAIL s1_hit_pos: got %0d expected 12", ps); else passes++;
    checks++; if (ic != 15) $display("FAIL s1_idle_cycle: got %0d expected 15", ic); else passes++;
    checks++; if (ammo !== 4'd2) $display("FAIL s1_ammo: got %0d expected 2", ammo); else passes++;
    checks++; if (score !== 8'd1) $display("FAIL s1_score: got %0d expected 1", score); else passes++;
  endtask

  task automatic test_hold_fire();
    int strikes_hold, strikes_cd;
    logic prev;
    reset_dut();
    lane_sel = 2'd0;
    strikes_hold = 0; prev = 0;
    fire = 1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (hit != 3'b000 && !prev) strikes_hold++;
      prev = (hit != 3'b000);
    end
    fire = 0;
    tick();
    strikes_cd = 0; prev = 0;
    fire = 1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) fire = 0;
      if (c == 9) fire = 1;
      if (c == 10) fire = 0;
      if (hit != 3'b000 && !prev) strikes_cd++;
      prev = (hit != 3'b000);
    end
    checks++; if (strikes_hold != 1) $display("FAIL hold_strikes: got %0d expected 1", strikes_hold); else passes++;
    checks++; if (strikes_cd != 1) $display("FAIL cooldown_refire_strikes: got %0d expected 1", strikes_cd); else passes++;
    checks++; if (ammo !== 4'd1) $display("FAIL hold_ammo: got %0d expected 1", ammo); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL hold_busy_end: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_ammo_reload();
    int fh, lh, ic, nbusy;
    logic [2:0] ho;
    logic [4:0] ps;
    logic b1;
    logic [3:0] a9, a10;
    reset_dut();
    for (int k = 0; k < 3; k++) run_strike(2'd0, 0, -1, 3'b000, 0, fh, lh, ho, ps, ic, b1);
    checks++; if (ammo !== 4'd0) $display("FAIL empty_ammo: got %0d expected 0", ammo); else passes++;
    run_strike(2'd0, 0, -1, 3'b000, 0, fh, lh, ho, ps, ic, b1);
    checks++; if (fh != -1) $display("FAIL empty_no_strike: got first hit %0d expected -1", fh); else passes++;
    checks++; if (ic != 1) $display("FAIL empty_not_busy: got idle cycle %0d expected 1", ic); else passes++;
    checks++; if (ammo !== 4'd0) $display("FAIL empty_ammo_hold: got %0d expected 0", ammo); else passes++;
    nbusy = 0; a9 = 4'hF; a10 = 4'hF;
    reload = 1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) reload = 0;
      if (c == 9) a9 = ammo;
      if (c == 10) a10 = ammo;
      if (busy) nbusy++;
      else break;
    end
    checks++; if (nbusy != 10) $display("FAIL reload_busy_len: got %0d expected 10", nbusy); else passes++;
    checks++; if (a9 !== 4'd0) $display("FAIL reload_ammo_c9: got %0d expected 0", a9); else passes++;
    checks++; if (a10 !== 4'd3) $display("FAIL reload_ammo_c10: got %0d expected 3", a10); else passes++;
    checks++; if (ammo !== 4'd3) $display("FAIL reload_ammo_end: got %0d expected 3", ammo); else passes++;
    run_strike(2'd0, 0, -1, 3'b000, 0, fh, lh, ho, ps, ic, b1);
    reload = 1;
    run_strike(2'd1, 0, -1, 3'b000, 0, fh, lh, ho, ps, ic, b1);
    reload = 0;
    checks++; if (fh != 3) $display("FAIL fire_reload_strike: got first hit %0d expected 3", fh); else passes++;
    checks++; if (ic != 15) $display("FAIL fire_reload_idle: got %0d expected 15", ic); else passes++;
    checks++; if (ammo !== 4'd1) $display("FAIL fire_reload_ammo: got %0d expected 1", ammo); else passes++;
  endtask

  task automatic test_aim();
    reset_dut();
    for (int k = 0; k < 30; k++) begin
      aim_right = 1; tick(); aim_right = 0; tick();
    end
    checks++; if (aim_pos !== 5'd24) $display("FAIL aim_right_sat: got %0d expected 24", aim_pos); else passes++;
    for (int k = 0; k < 5; k++) begin
      aim_left = 1; tick(); aim_left = 0; tick();
    end
    checks++; if (aim_pos !== 5'd19) $display("FAIL aim_left5: got %0d expected 19", aim_pos); else passes++;
    aim_left = 1; aim_right = 1; tick(); aim_left = 0; aim_right = 0; tick();
    checks++; if (aim_pos !== 5'd19) $display("FAIL aim_both: got %0d expected 19", aim_pos); else passes++;
    aim_left = 1;
    for (int k = 0; k < 6; k++) tick();
    aim_left = 0; tick();
    checks++; if (aim_pos !== 5'd18) $display("FAIL aim_hold: got %0d expected 18", aim_pos); else passes++;
    for (int k = 0; k < 30; k++) begin
      aim_left = 1; tick(); aim_left = 0; tick();
    end
    checks++; if (aim_pos !== 5'd0) $display("FAIL aim_left_sat: got %0d expected 0", aim_pos); else passes++;
  endtask

  task automatic test_lane_damage();
    int fh, lh, ic;
    logic [2:0] ho;
    logic [4:0] ps;
    logic b1;
    reset_dut();
    run_strike(2'd3, 0, -1, 3'b000, 0, fh, lh, ho, ps, ic, b1);
    checks++; if (fh != -1) $display("FAIL lane3_no_strike: got first hit %0d expected -1", fh); else passes++;
    checks++; if (ammo !== 4'd3) $display("FAIL lane3_ammo: got %0d expected 3", ammo); else passes++;
    run_strike(2'd1, 2, 10, 3'b001, 4, fh, lh, ho, ps, ic, b1);
    checks++; if (ho !== 3'b010) $display("FAIL lane1_hit_val: got %b expected 010", ho); else passes++;
    checks++; if (score !== 8'd0) $display("FAIL wrong_lane_score: got %0d expected 0", score); else passes++;
    checks++; if (ps !== 5'd12) $display("FAIL hit_pos_latched: got %0d expected 12", ps); else passes++;
    checks++; if (aim_pos !== 5'd13) $display("FAIL aim_during_strike: got %0d expected 13", aim_pos); else passes++;
    run_strike(2'd0, 3, 3, 3'b001, 0, fh, lh, ho, ps, ic, b1);
    checks++; if (score !== 8'd0) $display("FAIL early_damage_score: got %0d expected 0", score); else passes++;
    run_strike(2'd0, 8, 14, 3'b001, 0, fh, lh, ho, ps, ic, b1);
    checks++; if (score !== 8'd0) $display("FAIL late_damage_score: got %0d expected 0", score); else passes++;
    checks++; if (ammo !== 4'd0) $display("FAIL lane_ammo: got %0d expected 0", ammo); else passes++;
    reset_dut();
    run_strike(2'd0, 7, 7, 3'b001, 0, fh, lh, ho, ps, ic, b1);
    checks++; if (score !== 8'd1) $display("FAIL edge_window_score: got %0d expected 1", score); else passes++;
    run_strike(2'd2, 4, 7, 3'b111, 0, fh, lh, ho, ps, ic, b1);
    checks++; if (score !== 8'd2) $display("FAIL once_per_strike_score: got %0d expected 2", score); else passes++;
    checks++; if (ho !== 3'b100) $display("FAIL lane2_hit_val: got %b expected 100", ho); else passes++;
  endtask

  task automatic test_reset_mid_strike();
    reset_dut();
    loop_en = 1;
    lane_sel = 2'd1;
    fire = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) fire = 0;
    end
    checks++; if (hit !== 3'b010) $display("FAIL mid_hit_before: got %b expected 010", hit); else passes++;
    #2;
    rst = 0;
    #1;
    checks++; if (hit !== 3'b000) $display("FAIL mid_rst_hit: got %b expected 000", hit); else passes++;
    checks++; if (ammo !== 4'd3) $display("FAIL mid_rst_ammo: got %0d expected 3", ammo); else passes++;
    checks++; if (score !== 8'd0) $display("FAIL mid_rst_score: got %0d expected 0", score); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else passes++;
    tick();
    rst = 1;
    for (int c = 0; c < 5; c++) tick();
    loop_en = 0;
    checks++; if (score !== 8'd0 || busy !== 1'b0) $display("FAIL post_rst_idle: got score %0d busy %b expected 0 0", score, busy); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    hit_dly = 3'b000;
    test_reset();
    test_single_strike();
    test_hold_fire();
    test_ammo_reload();
    test_aim();
    test_lane_damage();
    test_reset_mid_strike();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
